// File: rtl/darkbus_pkg.sv
// Shared types and constants for the device_bus to AXI4-Lite bridge.
package darkbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_ACK
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
    localparam int unsigned DEFAULT_TIMEOUT  = 1024;

    // Word-aligned window offset relocated onto the AXI map, wrapping at 2^32.
    function automatic logic [31:0] axi_addr(input logic [31:0] base, input logic [31:0] offset);
        return base + (offset & 32'hFFFF_FFFC);
    endfunction

endpackage

// File: rtl/darkbus_axil_bridge_if.sv
// Bundle of device_bus responder signals and the AXI4-Lite master channels.
interface darkbus_axil_bridge_if;
    logic        EN;
    logic        RE;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] ADDR;
    logic [31:0] WDATA_I;
    logic [31:0] RDATA_O;
    logic        RACK;
    logic        WACK;
    logic        ERR;

    logic [31:0] M_AWADDR;
    logic        M_AWVALID;
    logic        M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WVALID;
    logic        M_WREADY;
    logic [1:0]  M_BRESP;
    logic        M_BVALID;
    logic        M_BREADY;
    logic [31:0] M_ARADDR;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RVALID;
    logic        M_RREADY;

    // The bridge: answers the core bus and masters the AXI channels.
    modport master (
        input  EN, RE, WE, BE, ADDR, WDATA_I,
        output RDATA_O, RACK, WACK, ERR,
        output M_AWADDR, M_AWVALID, input M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
        input  M_BRESP, M_BVALID, output M_BREADY,
        output M_ARADDR, M_ARVALID, input M_ARREADY,
        input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
    );

    // The surroundings: core-side requester plus the AXI slave.
    modport slave (
        output EN, RE, WE, BE, ADDR, WDATA_I,
        input  RDATA_O, RACK, WACK, ERR,
        input  M_AWADDR, M_AWVALID, output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
        output M_BRESP, M_BVALID, input M_BREADY,
        input  M_ARADDR, M_ARVALID, output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
    );
endinterface

// File: rtl/darkbus_timeout.sv
// Saturating phase-wait counter; pulses o_expired on the cycle the limit is reached.
module darkbus_timeout #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);
    logic [W-1:0] r_count;

    // A zero limit disables expiry entirely.
    assign o_expired = i_en && (i_limit != '0) && (r_count == i_limit - 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr || o_expired) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/darkbus_axil_bridge.sv
// device_bus responder that turns each read/write into one AXI4-Lite transaction,
// with address relocation and a per-phase response timeout.
module darkbus_axil_bridge
    import darkbus_pkg::*;
#(
    parameter logic [31:0] AXI_BASE = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
    input logic XCLK,
    input logic XRES,
    darkbus_axil_bridge_if.master bus
);
    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic        r_aw_done, r_w_done;
    logic        r_rack, r_wack, r_err;

    logic        w_waiting, w_aw_hs, w_w_hs, w_progress, w_expired, w_timeout, w_tmo_clr;

    assign w_waiting = r_state inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP};
    assign w_aw_hs   = r_awvalid && bus.M_AWREADY;
    assign w_w_hs    = r_wvalid && bus.M_WREADY;

    always_comb begin
        w_progress = 1'b0;
        case (r_state)
            ST_WR_REQ:  w_progress = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
            ST_WR_RESP: w_progress = r_bready && bus.M_BVALID;
            ST_RD_REQ:  w_progress = w_aw_hs || (r_arvalid && bus.M_ARREADY);
            ST_RD_RESP: w_progress = r_rready && bus.M_RVALID;
            default:    w_progress = 1'b0;
        endcase
    end

    // A handshake landing on the expiry cycle still counts as a normal completion.
    assign w_timeout = w_expired && !w_progress;
    assign w_tmo_clr = !w_waiting || w_progress;

    darkbus_timeout #(.W(32)) u_timeout (
        .i_clk     (XCLK),
        .i_rst     (XRES),
        .i_clr     (w_tmo_clr),
        .i_en      (w_waiting),
        .i_limit   (32'(TIMEOUT)),
        .o_expired (w_expired)
    );

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rack    <= 1'b0;
            r_wack    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.EN && (bus.WE || bus.RE)) begin
                        r_addr  <= axi_addr(AXI_BASE, bus.ADDR);
                        r_wstrb <= bus.BE;
                        r_wdata <= bus.WDATA_I;
                    end
                    if (bus.EN && bus.WE) begin
                        r_state   <= ST_WR_REQ;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (bus.RE) r_err <= 1'b1;
                    end else if (bus.EN && bus.RE) begin
                        r_state   <= ST_RD_REQ;
                        r_arvalid <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    if (w_timeout) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_err     <= 1'b1;
                        r_wack    <= 1'b1;
                        r_state   <= ST_ACK;
                    end else begin
                        if (w_aw_hs) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if (w_progress) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (w_timeout || w_progress) begin
                        r_bready <= 1'b0;
                        r_wack   <= 1'b1;
                        r_state  <= ST_ACK;
                        if (w_timeout || (bus.M_BRESP != AXI_RESP_OKAY)) r_err <= 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    if (w_timeout) begin
                        r_arvalid <= 1'b0;
                        r_err     <= 1'b1;
                        r_rdata   <= ERR_DATA;
                        r_rack    <= 1'b1;
                        r_state   <= ST_ACK;
                    end else if (r_arvalid && bus.M_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (w_timeout || w_progress) begin
                        r_rready <= 1'b0;
                        r_rack   <= 1'b1;
                        r_state  <= ST_ACK;
                        if (!w_timeout && (bus.M_RRESP == AXI_RESP_OKAY)) begin
                            r_rdata <= bus.M_RDATA;
                        end else begin
                            r_rdata <= ERR_DATA;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_rack  <= 1'b0;
                    r_wack  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.RDATA_O   = r_rdata;
    assign bus.RACK      = r_rack;
    assign bus.WACK      = r_wack;
    assign bus.ERR       = r_err;
    assign bus.M_AWADDR  = r_addr;
    assign bus.M_AWVALID = r_awvalid;
    assign bus.M_WDATA   = r_wdata;
    assign bus.M_WSTRB   = r_wstrb;
    assign bus.M_WVALID  = r_wvalid;
    assign bus.M_BREADY  = r_bready;
    assign bus.M_ARADDR  = r_addr;
    assign bus.M_ARVALID = r_arvalid;
    assign bus.M_RREADY  = r_rready;
endmodule

// File: tb/tb_darkbus_axil_bridge.sv
// Directed plus randomized bench for darkbus_axil_bridge against a transaction-level model.
module tb_darkbus_axil_bridge;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          TO    = 8;
    localparam logic [31:0] EDATA = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic        err_m;
    logic [31:0] rdata_m;

    darkbus_axil_bridge_if bus ();

    darkbus_axil_bridge #(
        .AXI_BASE (BASE),
        .TIMEOUT  (TO),
        .ERR_DATA (EDATA)
    ) dut (
        .XCLK (clk),
        .XRES (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic clear_slave();
        bus.M_AWREADY = 1'b0;
        bus.M_WREADY  = 1'b0;
        bus.M_BVALID  = 1'b0;
        bus.M_BRESP   = 2'b00;
        bus.M_ARREADY = 1'b0;
        bus.M_RVALID  = 1'b0;
        bus.M_RRESP   = 2'b00;
        bus.M_RDATA   = '0;
    endtask

    // One core request against a slave with the given per-channel wait cycles.
    task automatic run_txn(input string nm, input bit we, input bit re, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d,
                           input logic [1:0] resp, input logic [31:0] rd, input bit hold);
        bit is_wr = we;
        bit tmo;
        int d1, d2, exp_ack;
        int ack_at = -1, racks = 0, wacks = 0, awc = 0, wc = 0, arc = 0;
        int awn = 0, wn = 0, bn = 0, arn = 0, rn = 0;
        bit aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0;
        logic [31:0] cap_addr = 'x, cap_wdata = 'x, rdata_ack = 'x;
        logic [3:0]  cap_strb = 'x;

        // Reference: each phase lasts until its last handshake, capped at TO cycles.
        d1 = is_wr ? imax(aw_d, w_d) + 1 : ar_d + 1;
        d2 = is_wr ? b_d + 1 : r_d + 1;
        if (d1 > TO) begin
            tmo = 1; exp_ack = 1 + TO;
        end else if (d2 > TO) begin
            tmo = 1; exp_ack = 1 + d1 + TO;
        end else begin
            tmo = 0; exp_ack = 1 + d1 + d2;
        end
        if (!is_wr && re) rdata_m = (tmo || resp != 2'b00) ? EDATA : rd;
        if ((we && re) || tmo || resp != 2'b00) err_m = 1'b1;

        @(negedge clk);
        bus.EN = 1'b1; bus.WE = we; bus.RE = re;
        bus.ADDR = addr; bus.BE = be; bus.WDATA_I = wd;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (!hold && cyc == 1) begin
                bus.EN = 1'b0; bus.WE = 1'b0; bus.RE = 1'b0;
            end
            if ((bus.RACK || bus.WACK) && ack_at < 0) begin
                ack_at = cyc;
                rdata_ack = bus.RDATA_O;
                bus.EN = 1'b0; bus.WE = 1'b0; bus.RE = 1'b0;
            end
            racks += int'(bus.RACK);
            wacks += int'(bus.WACK);
            awc += int'(bus.M_AWVALID);
            wc  += int'(bus.M_WVALID);
            arc += int'(bus.M_ARVALID);
            // Response channels start the cycle after their address/data handshakes.
            if (aw_done && w_done && !b_done) begin
                if (bn >= b_d) begin
                    bus.M_BVALID = 1'b1; bus.M_BRESP = resp;
                    if (bus.M_BREADY) b_done = 1;
                end
                bn++;
            end else bus.M_BVALID = 1'b0;
            if (ar_done && !r_done) begin
                if (rn >= r_d) begin
                    bus.M_RVALID = 1'b1; bus.M_RRESP = resp; bus.M_RDATA = rd;
                    if (bus.M_RREADY) r_done = 1;
                end
                rn++;
            end else bus.M_RVALID = 1'b0;
            bus.M_AWREADY = 1'b0;
            if (bus.M_AWVALID && !aw_done) begin
                if (awn >= aw_d) begin
                    bus.M_AWREADY = 1'b1; aw_done = 1; cap_addr = bus.M_AWADDR;
                end
                awn++;
            end
            bus.M_WREADY = 1'b0;
            if (bus.M_WVALID && !w_done) begin
                if (wn >= w_d) begin
                    bus.M_WREADY = 1'b1; w_done = 1;
                    cap_wdata = bus.M_WDATA; cap_strb = bus.M_WSTRB;
                end
                wn++;
            end
            bus.M_ARREADY = 1'b0;
            if (bus.M_ARVALID && !ar_done) begin
                if (arn >= ar_d) begin
                    bus.M_ARREADY = 1'b1; ar_done = 1; cap_addr = bus.M_ARADDR;
                end
                arn++;
            end
            if (ack_at >= 0 && cyc >= ack_at + 2) break;
        end
        clear_slave();
        bus.EN = 1'b0; bus.WE = 1'b0; bus.RE = 1'b0;

        check({nm, "_ack_cycle"}, ack_at, exp_ack);
        check({nm, "_wack_count"}, wacks, is_wr ? 1 : 0);
        check({nm, "_rack_count"}, racks, is_wr ? 0 : 1);
        check({nm, "_rdata_at_ack"}, rdata_ack, rdata_m);
        check({nm, "_rdata_hold"}, bus.RDATA_O, rdata_m);
        check({nm, "_err"}, bus.ERR, err_m);
        if (is_wr) begin
            check({nm, "_awvalid_cycles"}, awc, imin(aw_d + 1, TO));
            check({nm, "_wvalid_cycles"}, wc, imin(w_d + 1, TO));
            check({nm, "_arvalid_cycles"}, arc, 0);
            if (!tmo) begin
                check({nm, "_awaddr"}, cap_addr, BASE + (addr & ~32'h3));
                check({nm, "_wdata"}, cap_wdata, wd);
                check({nm, "_wstrb"}, cap_strb, be);
            end
        end else begin
            check({nm, "_arvalid_cycles"}, arc, imin(ar_d + 1, TO));
            check({nm, "_awvalid_cycles"}, awc + wc, 0);
            if (ar_done) check({nm, "_araddr"}, cap_addr, BASE + (addr & ~32'h3));
        end
    endtask

    initial begin
        int nquiet;
        bus.EN = 1'b0; bus.RE = 1'b0; bus.WE = 1'b0;
        bus.BE = '0; bus.ADDR = '0; bus.WDATA_I = '0;
        clear_slave();
        err_m = 1'b0;
        rdata_m = '0;

        #1 rst = 1'b1;
        #2;
        check("reset_rdata", bus.RDATA_O, 32'h0);
        check("reset_acks", {bus.RACK, bus.WACK, bus.ERR}, 3'b000);
        check("reset_valids", {bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}, 3'b000);
        check("reset_readies", {bus.M_BREADY, bus.M_RREADY}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_txn("rd_min", 0, 1, 32'h10, 4'hF, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 0);
        run_txn("wr_awdelay", 1, 0, 32'h8, 4'b0011, 32'hAABB_CCDD, 2, 0, 1, 0, 0, 2'b00, 32'h0, 0);
        run_txn("rd_slverr", 0, 1, 32'h20, 4'hF, 32'h0, 0, 0, 0, 1, 2, 2'b10, 32'h5555_AAAA, 0);
        run_txn("wr_after_err", 1, 0, 32'h24, 4'hF, 32'h0102_0304, 0, 1, 0, 0, 0, 2'b00, 32'h0, 0);
        run_txn("rd_after_err", 0, 1, 32'h28, 4'hF, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 1);
        run_txn("rd_timeout", 0, 1, 32'h30, 4'hF, 32'h0, 0, 0, 0, 1000, 0, 2'b00, 32'h0, 0);
        run_txn("wr_be0", 1, 0, 32'hFFFF_FFFF, 4'b0000, 32'h7777_8888, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);

        // Fresh reset so the simultaneous RE&WE case is seen setting ERR from clear.
        rst = 1'b1;
        #1 rst = 1'b0;
        err_m = 1'b0;
        rdata_m = '0;
        run_txn("wr_rdwe", 1, 1, 32'h44, 4'hC, 32'h1357_9BDF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);

        // Reset while waiting for the write response.
        @(negedge clk);
        bus.EN = 1'b1; bus.WE = 1'b1; bus.RE = 1'b0; bus.ADDR = 32'h50;
        bus.M_AWREADY = 1'b1; bus.M_WREADY = 1'b1;
        @(negedge clk);
        bus.EN = 1'b0; bus.WE = 1'b0;
        for (int i = 0; i < 10 && !bus.M_BREADY; i++) @(negedge clk);
        check("rst_wait_bready", bus.M_BREADY, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_bready_wack", {bus.M_BREADY, bus.WACK}, 2'b00);
        check("rst_mid_valids", {bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}, 3'b000);
        check("rst_mid_err", bus.ERR, 1'b0);
        clear_slave();
        @(negedge clk);
        rst = 1'b0;
        err_m = 1'b0;
        rdata_m = '0;
        run_txn("rd_post_rst", 0, 1, 32'h60, 4'hF, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 0);

        // A request without EN must be ignored.
        @(negedge clk);
        bus.EN = 1'b0; bus.WE = 1'b1; bus.RE = 1'b1;
        nquiet = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nquiet += int'(bus.RACK) + int'(bus.WACK) + int'(bus.M_AWVALID) + int'(bus.M_ARVALID);
        end
        bus.WE = 1'b0; bus.RE = 1'b0;
        check("no_en_activity", nquiet, 0);
        check("no_en_err", bus.ERR, err_m);

        for (int n = 0; n < 24; n++) begin
            bit rwe, rre;
            logic [1:0] rresp;
            int kind = int'($urandom_range(0, 5));
            rwe = (kind < 3);
            rre = (kind >= 3) || (kind == 0 && $urandom_range(0, 2) == 0);
            rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn("rand", rwe, rre, $urandom, 4'($urandom_range(0, 15)), $urandom,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), rresp, $urandom,
                    bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/darkbus_axil_bridge.md
Name: darkbus_axil_bridge

Overview:
- Responder (target) end of the device_bus: sits behind the memory-map decoder in place of a local device (e.g. external RAM or flash window).
- Converts each enabled device_bus read/write into one AXI4-Lite master transaction and returns RACK/WACK with read data.
- Bus-side DATA is carried as split in/out ports; the instantiating wrapper ties them to the tristate interface.
- Adds a configurable base address and a response timeout so a hung slave cannot stall the core.

Parameters:
AXI_BASE, 32'h0000_0000, added to the bus offset address to form the AXI address
TIMEOUT, 1024, cycles to wait in any AXI phase before forcing completion; 0 disables the timeout
ERR_DATA, 32'hDEAD_BEEF, read data returned on SLVERR/DECERR or timeout

Ports:
XCLK in 1 clock
XRES in 1 reset; asynchronous, active-high
EN in 1 device selected by decoder
RE in 1 read request
WE in 1 write request
BE in 4 byte enables
ADDR in 32 offset address within window
WDATA_I in 32 write data from core
RDATA_O out 32 read data to core
RACK out 1 read acknowledge
WACK out 1 write acknowledge
ERR out 1 sticky error flag
M_AWADDR/M_AWVALID/M_AWREADY out/out/in 32/1/1 AXI write address
M_WDATA/M_WSTRB/M_WVALID/M_WREADY out/out/out/in 32/4/1/1 AXI write data
M_BRESP/M_BVALID/M_BREADY in/in/out 2/1/1 AXI write response
M_ARADDR/M_ARVALID/M_ARREADY out/out/in 32/1/1 AXI read address
M_RDATA/M_RRESP/M_RVALID/M_RREADY in/in/in/out 32/2/1/1 AXI read data

Behaviour:
- Reset (async): all outputs 0, including RDATA_O=0, ERR=0, all VALID/READY low, state IDLE, timeout counter 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK.
- IDLE transitions:
  - EN&WE -> WR_REQ; WE wins if RE is also high, and ERR is set.
  - EN&RE&!WE -> RD_REQ.
  - On either transition, latch addr = AXI_BASE + {ADDR[31:2],2'b00} (modulo 2^32), plus BE and WDATA_I.
- WR_REQ:
  - AWVALID and WVALID rise in the cycle after the request.
  - Each is held until its own handshake; AW and W complete independently, in either order or the same cycle.
  - When both are done -> WR_RESP with BREADY=1.
  - WSTRB = BE; BE=0 is still issued.
- WR_RESP: on BVALID -> ACK; BRESP!=OKAY sets ERR.
- RD_REQ: ARVALID held until ARREADY -> RD_RESP with RREADY=1.
- RD_RESP: on RVALID, capture RDATA_O = RRESP==OKAY ? M_RDATA : ERR_DATA -> ACK; RRESP!=OKAY sets ERR.
- ACK:
  - Exactly one-cycle pulse of RACK or WACK, matching the request type -> IDLE.
  - RDATA_O holds its value until the next read completes.
  - The request is consumed at the ack; a request still held in the ack cycle is not re-sampled. IDLE samples again the following cycle.
- Minimum latency with ready/valid always high: request at cycle 0, A/W valid at 1, response at 2, ack at 3.
- Timeout:
  - The counter clears on every state change and increments in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - Reaching TIMEOUT drops all VALID/READY, sets ERR, returns ERR_DATA on reads, and goes to ACK.
- EN is only sampled in IDLE; EN dropping mid-transaction does not abort it.
- Reset asserted mid-transaction immediately drops all VALIDs; the AXI slave must also be reset.
- ERR clears only on reset.

Decomposition:
- darkbus_pkg:
  - FSM state enum.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - Default ERR_DATA and TIMEOUT constants.
- One sub-module: darkbus_timeout. It is a loadable saturating counter with inputs clr, en and limit, and a one-cycle expired output; limit==0 never expires.

Test Plan:
- Read at ADDR=0x10, AXI_BASE=0x4000_0000, slave always ready and returning 0x1234_5678 -> ARADDR=0x4000_0010, RACK pulses at cycle 3 for one cycle, RDATA_O=0x1234_5678.
- Write ADDR=0x8, BE=4'b0011, WDATA=0xAABB_CCDD; AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held 3 cycles, WSTRB=0011, a single WACK follows BVALID.
- Read returning RRESP=SLVERR -> RDATA_O=0xDEAD_BEEF, RACK pulses, ERR=1 and stays 1 across later OKAY transactions.
- TIMEOUT=8, slave never asserts ARREADY -> after 8 cycles ARVALID drops, RACK pulses, RDATA_O=ERR_DATA, ERR=1.
- EN&RE&WE together -> a write is performed (WACK, no RACK) and ERR=1. Then XRES asserted while WR_RESP waits -> BREADY and WACK are 0 in that same cycle, FSM is IDLE after release.
